synapse_accum: RTL and testbench

//  Presynaptic stage feeding the soma's 16-bit weight input. Receives spike events carrying a synapse

---
 rtl/synapse_accum.sv | 198 +++++++++++++++++++
 tb/tb_synapse_accum.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_accum.sv
// synapse_accum
// Presynaptic accumulation stage in front of the soma. Spike events carry a
// synapse index; each accepted event is queued, its programmed weight is
// fetched from the weight RAM and added into a saturating accumulator. When a
// step pulse closes the timestep, the queue is drained and the total is
// presented to the soma for one cycle.
//
// Ports:
//   clk, rst      clock (posedge) and synchronous active-high reset
//   wr_en/addr/data  weight RAM programming port, usable in any state
//   spk_valid/ready/addr  spike event handshake into the event FIFO
//   step          one-cycle pulse closing the current timestep
//   weight        timestep total, meaningful while weight_valid is high
//   weight_valid  one-cycle pulse per closed timestep
//   sat           sticky saturation flag of the current timestep
//   step_err      one-cycle pulse when a step was dropped in DRAIN/EMIT
module synapse_accum #(
    parameter int N_SYN      = 16,
    parameter int W_WIDTH    = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(N_SYN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               spk_valid,
    output logic               spk_ready,
    input  logic [AW-1:0]      spk_addr,
    input  logic               step,
    output logic [W_WIDTH-1:0] weight,
    output logic               weight_valid,
    output logic               sat,
    output logic               step_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ACC,
        DRAIN,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [W_WIDTH-1:0] ram [N_SYN];
    logic [AW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic [AW-1:0]      rd_addr;
    logic [W_WIDTH-1:0] rdata;
    logic [W_WIDTH-1:0] acc;
    logic [W_WIDTH:0]   sum_wide;
    logic               step_pend;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    // Intake is closed while draining so the closing timestep cannot grow
    // without bound and so EMIT always sees a settled total.
    assign spk_ready  = !fifo_full && (state != DRAIN) && (state != EMIT);
    assign push       = spk_valid && spk_ready;
    assign sum_wide   = {1'b0, acc} + {1'b0, rdata};

    // Weight RAM: never reset so programming survives rst. The read and a
    // same-address write share an edge, so the read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
        if (state == READ) begin
            rdata <= ram[rd_addr];
        end
    end

    // Event FIFO storage and the popped-address register feeding the RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= spk_addr;
        end
        if (pop) begin
            rd_addr <= fifo_mem[rd_ptr];
        end
    end

    // FIFO pointers and occupancy; pointers wrap because depth is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state logic. A pending step forces every ACC into DRAIN so the
    // queue empties before EMIT.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = READ;
                end else if (step) begin
                    state_nxt = DRAIN;
                end
            end
            READ: begin
                state_nxt = ACC;
            end
            ACC: begin
                if (step || step_pend) begin
                    state_nxt = DRAIN;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = READ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = READ;
                end else begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, accumulator, step latch and the soma-facing outputs.
    // weight/weight_valid load on the DRAIN->EMIT edge so the pulse is seen
    // during EMIT while sat still shows this timestep's flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            sat          <= 1'b0;
            weight       <= '0;
            weight_valid <= 1'b0;
            step_err     <= 1'b0;
            step_pend    <= 1'b0;
        end else begin
            state        <= state_nxt;
            weight_valid <= (state_nxt == EMIT);
            step_err     <= step && ((state == DRAIN) || (state == EMIT));

            if (state_nxt == EMIT) begin
                weight <= acc;
            end

            if (state == EMIT) begin
                step_pend <= 1'b0;
            end else if (step && ((state == IDLE) || (state == READ) || (state == ACC))) begin
                step_pend <= 1'b1;
            end

            if (state == ACC) begin
                if (sum_wide[W_WIDTH]) begin
                    acc <= '1;
                    sat <= 1'b1;
                end else begin
                    acc <= sum_wide[W_WIDTH-1:0];
                end
            end else if (state == EMIT) begin
                acc <= '0;
                sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_synapse_accum.sv
// tb_synapse_accum
// Scoreboarded bench for synapse_accum. Stimulus closes timesteps and pushes
// the expected total (sum of weights of accepted spikes, clamped at 16 bits)
// into a queue; a monitor pops and compares on every weight_valid pulse.
module tb_synapse_accum;

    localparam int AW   = 4;
    localparam int W    = 16;
    localparam longint WMAX = 65535;

    typedef struct {
        logic [W-1:0] w;
        logic         s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          spk_valid;
    logic          spk_ready;
    logic [AW-1:0] spk_addr;
    logic          step;
    logic [W-1:0]  weight;
    logic          weight_valid;
    logic          sat;
    logic          step_err;

    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     emit_cnt = 0;
    int     pushed = 0;
    int     step_err_cnt = 0;
    int     last_valid_cyc = -1;
    bit     saw_full = 1'b0;
    longint ts_sum = 0;
    logic [W-1:0] model_w [16];
    exp_t   exp_q[$];

    synapse_accum dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .spk_valid    (spk_valid),
        .spk_ready    (spk_ready),
        .spk_addr     (spk_addr),
        .step         (step),
        .weight       (weight),
        .weight_valid (weight_valid),
        .sat          (sat),
        .step_err     (step_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Close the timestep in the reference model: total is clamped, sat is
    // set whenever the true sum exceeded the 16-bit range.
    task automatic closeTimestep();
        exp_t e;
        e.w = (ts_sum > WMAX) ? 16'hFFFF : ts_sum[W-1:0];
        e.s = (ts_sum > WMAX);
        exp_q.push_back(e);
        ts_sum = 0;
        pushed++;
    endtask

    task automatic applyStimulus(input bit v, input int a, input bit s, output bit accepted);
        @(negedge clk);
        spk_valid = v;
        spk_addr  = a[AW-1:0];
        step      = s;
        wr_en     = 1'b0;
        accepted  = v && spk_ready;
        if (v && !spk_ready) saw_full = 1'b1;
        if (accepted) ts_sum += longint'(model_w[a]);
        if (s) closeTimestep();
    endtask

    task automatic drive(input bit v, input int a, input bit s);
        bit acc_flag;
        applyStimulus(v, a, s, acc_flag);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    task automatic writeWeight(input int a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = a[AW-1:0];
        wr_data   = d;
        spk_valid = 1'b0;
        step      = 1'b0;
        model_w[a] = d;
    endtask

    task automatic waitEmits();
        int k = 0;
        while (emit_cnt != pushed && k < 400) begin
            drive(1'b0, 0, 1'b0);
            k++;
        end
        if (emit_cnt != pushed) begin
            checkOutput("emit_timeout", emit_cnt, pushed);
            exp_q.delete();
            pushed = emit_cnt;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst       = 1'b1;
        spk_valid = 1'b0;
        step      = 1'b0;
        wr_en     = 1'b0;
        exp_q.delete();
        ts_sum = 0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        pushed = emit_cnt;
    endtask

    task automatic checkResetState();
        @(negedge clk);
        checkOutput("rst_spk_ready", spk_ready, 1);
        checkOutput("rst_weight", weight, 0);
        checkOutput("rst_weight_valid", weight_valid, 0);
        checkOutput("rst_sat", sat, 0);
        checkOutput("rst_step_err", step_err, 0);
    endtask

    // Monitor: samples 1 ns after each rising edge, pops the scoreboard on
    // every weight_valid pulse and counts step_err pulses.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (weight_valid) begin
                emit_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_emit", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("weight", weight, e.w);
                    checkOutput("sat", sat, e.s);
                end
            end
            if (step_err) step_err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s_cyc;
        int acc_cnt;
        int err_before;
        bit a_ok;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        spk_valid = 1'b0; spk_addr = '0; step = 1'b0;
        for (int i = 0; i < 16; i++) model_w[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetState();

        for (int i = 0; i < 16; i++) writeWeight(i, W'($urandom_range(0, 3000)));

        // Basic sum of three spikes.
        writeWeight(3, 16'd10);
        writeWeight(5, 16'd20);
        drive(1'b1, 3, 1'b0);
        drive(1'b1, 5, 1'b0);
        drive(1'b1, 3, 1'b0);
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(4);
        checkOutput("weight_hold", weight, 40);

        // Empty timestep and step-to-pulse latency.
        drive(1'b0, 0, 1'b1);
        s_cyc = cyc;
        waitEmits();
        checkOutput("empty_latency", last_valid_cyc, s_cyc + 2);
        idleCycles(3);

        // Saturation, then a clean timestep clears sat.
        writeWeight(0, 16'hF000);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(2);
        drive(1'b1, 0, 1'b0);
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(3);

        // Write landing on the same edge as the RAM read: old value is used.
        writeWeight(4, 16'd100);
        idleCycles(2);
        drive(1'b1, 4, 1'b0);
        drive(1'b0, 0, 1'b0);
        writeWeight(4, 16'd200);
        model_w[4] = 16'd200;
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(2);
        drive(1'b1, 4, 1'b0);
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(3);

        // Back-to-back burst fills the FIFO; nothing may be lost.
        saw_full = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 15), 1'b0, a_ok);
            if (a_ok) acc_cnt++;
        end
        drive(1'b0, 0, 1'b1);
        waitEmits();
        checkOutput("fifo_full_seen", saw_full, 1);
        checkOutput("burst_accepted_ge8", (acc_cnt >= 8), 1);
        idleCycles(4);

        // Spike together with step is included; a second step in DRAIN is dropped.
        err_before = step_err_cnt;
        drive(1'b1, 7, 1'b1);
        @(negedge clk);
        spk_valid = 1'b0;
        step = 1'b1;
        checkOutput("ready_in_drain", spk_ready, 0);
        drive(1'b0, 0, 1'b0);
        waitEmits();
        idleCycles(6);
        checkOutput("step_err_pulses", step_err_cnt - err_before, 1);
        checkOutput("single_emit", emit_cnt, pushed);

        // Reset in the middle of a drain; RAM contents must survive.
        writeWeight(2, 16'd7);
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom_range(0, 15), 1'b0);
        drive(1'b0, 0, 1'b1);
        idleCycles(3);
        applyReset();
        checkResetState();
        drive(1'b1, 2, 1'b0);
        drive(1'b0, 0, 1'b1);
        waitEmits();
        idleCycles(3);

        // Randomized timesteps against the reference model.
        for (int t = 0; t < 25; t++) begin
            int nw;
            int ns;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) begin
                if ($urandom_range(0, 3) == 0)
                    writeWeight($urandom_range(0, 15), W'($urandom_range(0, 65535)));
                else
                    writeWeight($urandom_range(0, 15), W'($urandom_range(0, 4000)));
            end
            ns = $urandom_range(0, 12);
            for (int j = 0; j < ns; j++) begin
                int a;
                int k;
                a = $urandom_range(0, 15);
                idleCycles($urandom_range(0, 2));
                a_ok = 1'b0;
                k = 0;
                while (!a_ok && k < 50) begin
                    applyStimulus(1'b1, a, 1'b0, a_ok);
                    k++;
                end
                if (!a_ok) checkOutput("spike_accept_timeout", 0, 1);
            end
            if ($urandom_range(0, 2) == 0)
                drive(1'b1, $urandom_range(0, 15), 1'b1);
            else
                drive(1'b0, 0, 1'b1);
            waitEmits();
            idleCycles($urandom_range(1, 3));
        end

        idleCycles(5);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("step_err_total", step_err_cnt, 1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
